prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 133 +++++++++++++
 tb/tb_prog_loader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed big-endian byte stream, writes
// 16-bit words into code memory, then enables the processor.
module prog_loader #(
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr,
  output logic [15:0]       code_data,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [2:0]        state_dbg
);

  // Handshake: a byte moves on a rising edge where rx_valid and rx_ready are
  // both 1; rx_ready depends only on state and never on rx_valid.

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN_HI  = 3'd1,
    LEN_LO  = 3'd2,
    WORD_HI = 3'd3,
    WORD_LO = 3'd4,
    WRITE   = 3'd5,
    RUN     = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t            state, next;
  logic [7:0]        byte_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   last_idx;
  logic [TW-1:0]     tmo_cnt;
  logic              accept;
  logic              tmo_hit;
  logic              start_go;
  logic              len_bad;
  logic [15:0]       len_val;
  logic [16:0]       len_max;

  assign accept    = rx_ready & rx_valid;
  assign tmo_hit   = !accept && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign start_go  = start && !halt && (state == IDLE || state == RUN || state == ERROR);
  assign len_val   = {byte_q, rx_data};
  assign len_max   = 17'd1 << ADDR_W;
  assign len_bad   = (len_val == 16'd0) || ({1'b0, len_val} > len_max);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    if (halt && state != IDLE) begin
      next = IDLE;
    end else begin
      case (state)
        IDLE, RUN, ERROR: if (start) next = LEN_HI;
        LEN_HI:  if (accept) next = LEN_LO;
                 else if (tmo_hit) next = ERROR;
        LEN_LO:  if (accept) next = len_bad ? ERROR : WORD_HI;
                 else if (tmo_hit) next = ERROR;
        WORD_HI: if (accept) next = WORD_LO;
                 else if (tmo_hit) next = ERROR;
        WORD_LO: if (accept) next = WRITE;
                 else if (tmo_hit) next = ERROR;
        WRITE:   next = (idx == last_idx) ? RUN : WORD_HI;
        default: next = IDLE;
      endcase
    end
  end

  always_comb begin
    rx_ready  = (state == LEN_HI) || (state == LEN_LO) ||
                (state == WORD_HI) || (state == WORD_LO);
    code_w_en = (state == WRITE);
    run       = (state == RUN);
    busy      = rx_ready || (state == WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done      <= 1'b0;
      err       <= 1'b0;
      tmo_cnt   <= '0;
      idx       <= '0;
      last_idx  <= '0;
      byte_q    <= '0;
      code_addr <= '0;
      code_data <= '0;
    end else begin
      done <= (state == WRITE) && (next == RUN);

      if (start_go)                             err <= 1'b0;
      else if (next == ERROR && state != ERROR) err <= 1'b1;

      // Counts consecutive ready cycles without a byte; any acceptance restarts it.
      if (!rx_ready || accept || start_go) tmo_cnt <= '0;
      else                                 tmo_cnt <= tmo_cnt + TW'(1);

      if (start_go)
        idx <= '0;
      else if (state == WRITE && next == WORD_HI)
        idx <= idx + {{ADDR_W{1'b0}}, 1'b1};

      if (accept && (state == LEN_HI || state == WORD_HI))
        byte_q <= rx_data;

      if (state == LEN_LO && next == WORD_HI)
        last_idx <= len_val[ADDR_W:0] - {{ADDR_W{1'b0}}, 1'b1};

      // Address and data are captured on the edge into WRITE and held afterwards.
      if (state == WORD_LO && next == WRITE) begin
        code_addr <= idx[ADDR_W-1:0];
        code_data <= {byte_q, rx_data};
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of complete loads plus hand-written
// sequences for timeout, halt, start/halt collision and mid-write reset.
module tb_prog_loader;

  localparam int ADDR_W = 9;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, halt, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, code_w_en, run, busy, done, err;
  logic [ADDR_W-1:0] code_addr;
  logic [15:0]       code_data;
  logic [2:0]        state_dbg;

  prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .code_w_en(code_w_en), .code_addr(code_addr), .code_data(code_data),
    .run(run), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_we = -1;
  int done_cnt = 0;
  int last_addr = -1;
  logic [ADDR_W+15:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (code_w_en) begin
        if (first_we < 0) first_we = cyc;
        last_addr = int'(code_addr);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", code_addr, code_data);
        end else begin
          logic [ADDR_W+15:0] e;
          e = exp_q.pop_front();
          if ({code_addr, code_data} !== e) begin
            errors++;
            $display("FAIL write: got %0h/%0h expected %0h/%0h",
                     code_addr, code_data, e[ADDR_W+15:16], e[15:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    bit ok;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      acc = rx_ready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    rx_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL rx_accept: got no acceptance expected byte %0h accepted", b);
    end
  endtask

  task automatic push_exp(input int addr, input logic [15:0] data);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(addr);
    exp_q.push_back({a, data});
  endtask

  typedef struct {
    logic [15:0] len;
    logic [15:0] w0;
    logic [15:0] w1;
    int          gap;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'h0002, 16'h1234, 16'hABCD, 0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0000, 16'h0000, 0, 1'b1};
    vecs[2] = '{16'h0201, 16'h0000, 16'h0000, 0, 1'b1};
    vecs[3] = '{16'h0002, 16'h1234, 16'hABCD, 3, 1'b0};
    vecs[4] = '{16'h0001, 16'hBEEF, 16'h0000, 0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'h0000, 16'h0000, 1, 1'b1};
    vecs[6] = '{16'h0002, 16'h0000, 16'hFFFF, 7, 1'b0};

    rst_n = 1'b0; start = 1'b0; halt = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_run", run, 0);
    chk("rst_we", code_w_en, 0);
    chk("rst_ready", rx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", code_addr, 0);
    chk("rst_data", code_data, 0);
    chk("rst_state", state_dbg, 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      int start_cyc, done_base;
      first_we  = -1;
      done_base = done_cnt;
      start_cyc = cyc;
      do_start();
      chk("start_busy", busy, 1);
      chk("start_err_clr", err, 0);
      chk("start_run_clr", run, 0);
      if (!vecs[v].exp_err)
        for (int i = 0; i < int'(vecs[v].len); i++)
          push_exp(i, (i == 0) ? vecs[v].w0 : vecs[v].w1);
      send_byte(vecs[v].len[15:8], vecs[v].gap);
      send_byte(vecs[v].len[7:0], vecs[v].gap);
      if (!vecs[v].exp_err)
        for (int i = 0; i < int'(vecs[v].len); i++) begin
          logic [15:0] w;
          w = (i == 0) ? vecs[v].w0 : vecs[v].w1;
          send_byte(w[15:8], vecs[v].gap);
          send_byte(w[7:0], vecs[v].gap);
        end
      repeat (2) tick();
      chk("vec_run", run, vecs[v].exp_err ? 0 : 1);
      chk("vec_err", err, vecs[v].exp_err ? 1 : 0);
      chk("vec_busy", busy, 0);
      chk("vec_done", done_cnt - done_base, vecs[v].exp_err ? 0 : 1);
      chk("vec_queue", exp_q.size(), 0);
      if (!vecs[v].exp_err && vecs[v].gap == 0)
        chk("latency", first_we - start_cyc, 5);
    end

    // full-size load: 512 words
    begin
      int done_base;
      done_base = done_cnt;
      do_start();
      for (int i = 0; i < 512; i++) push_exp(i, 16'(i) ^ 16'hC3A5);
      send_byte(8'h02, 0);
      send_byte(8'h00, 0);
      for (int i = 0; i < 512; i++) begin
        logic [15:0] w;
        w = 16'(i) ^ 16'hC3A5;
        send_byte(w[15:8], 0);
        send_byte(w[7:0], 0);
      end
      repeat (2) tick();
      chk("full_last_addr", last_addr, 511);
      chk("full_run", run, 1);
      chk("full_done", done_cnt - done_base, 1);
      chk("full_queue", exp_q.size(), 0);
    end

    // inter-byte timeout boundary
    do_start();
    send_byte(8'h00, 0);
    repeat (TMO - 1) tick();
    chk("tmo_pre_state", state_dbg, 3'd2);
    chk("tmo_pre_err", err, 0);
    tick();
    chk("tmo_state", state_dbg, 3'd7);
    chk("tmo_err", err, 1);
    chk("tmo_run", run, 0);

    // start ignored mid-load, then halt in WORD_LO
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_state", state_dbg, 3'd3);
    send_byte(8'h12, 0);
    chk("pre_halt_state", state_dbg, 3'd4);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("halt_state", state_dbg, 3'd0);
    chk("halt_busy", busy, 0);
    chk("halt_ready", rx_ready, 0);

    // start+halt together in RUN
    do_start();
    push_exp(0, 16'h0F0F);
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h0F, 0);
    send_byte(8'h0F, 0);
    repeat (2) tick();
    chk("sh_pre_run", run, 1);
    start = 1'b1; halt = 1'b1;
    tick();
    start = 1'b0; halt = 1'b0;
    chk("sh_run", run, 0);
    chk("sh_state", state_dbg, 3'd0);
    chk("sh_busy", busy, 0);

    // asynchronous reset during WRITE
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    rx_valid = 1'b1;
    rx_data  = 8'hCD;
    tick();
    rx_valid = 1'b0;
    chk("mid_we", code_w_en, 1);
    chk("mid_data", code_data, 16'hABCD);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_we", code_w_en, 0);
    chk("ar_run", run, 0);
    chk("ar_busy", busy, 0);
    chk("ar_ready", rx_ready, 0);
    chk("ar_err", err, 0);
    chk("ar_done", done, 0);
    chk("ar_addr", code_addr, 0);
    chk("ar_data", code_data, 0);
    chk("ar_state", state_dbg, 3'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_state", state_dbg, 3'd0);
    chk("final_queue", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
